// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: streams K activation/weight vectors per tile into the
// systolic TPU, waits for the result, and drains 16 result rows to the
// output buffer, repeating for each programmed tile.
module tpu_tile_sequencer #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned K_MAX   = 144,
  parameter int unsigned TIMEOUT = 511
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_k,
  input  logic [7:0]        cfg_tiles,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_o_base,
  output logic              busy,
  output logic              irq_done,
  output logic              err_cfg,
  output logic              err_timeout,
  output logic [7:0]        tile_idx,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [127:0]      a_rdata,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [127:0]      w_rdata,
  output logic              tpu_in_valid,
  output logic [127:0]      tpu_mat_di,
  output logic [127:0]      tpu_wei_di,
  input  logic              tpu_out_valid,
  input  logic [127:0]      tpu_do,
  input  logic              tpu_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic [127:0]      o_wdata
);

  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned ROWS_W = 4;

  typedef enum logic [2:0] {
    IDLE, STREAM, FLUSH, WAIT, DRAIN, NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        j_q, j_d;
  logic [ROWS_W-1:0] row_q, row_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        tiles_q, tiles_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;

  logic              busy_d, irq_done_d, err_cfg_d, err_timeout_d;
  logic [7:0]        tile_idx_d;
  logic              a_rd_en_d, w_rd_en_d, o_wr_en_d;
  logic [ADDR_W-1:0] a_addr_d, w_addr_d, o_addr_d;
  logic [127:0]      o_wdata_d;
  logic              wd_hit;

  // Rows are counted locally, so the TPU last-row flag is not needed.
  logic unused_tpu_done;
  assign unused_tpu_done = tpu_done;

  // Vectors reach the TPU only while a read issued last cycle is returning.
  assign tpu_mat_di = tpu_in_valid ? a_rdata : 128'd0;
  assign tpu_wei_di = tpu_in_valid ? w_rdata : 128'd0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and next-output logic; a_addr and o_addr run linearly across
  // tiles since tile t starts exactly where tile t-1 ended.
  always_comb begin
    state_d       = state_q;
    j_d           = j_q;
    row_d         = row_q;
    wd_d          = wd_q;
    k_d           = k_q;
    tiles_d       = tiles_q;
    w_base_d      = w_base_q;
    busy_d        = busy;
    irq_done_d    = 1'b0;
    err_cfg_d     = 1'b0;
    err_timeout_d = err_timeout;
    tile_idx_d    = tile_idx;
    a_rd_en_d     = 1'b0;
    w_rd_en_d     = 1'b0;
    a_addr_d      = a_addr;
    w_addr_d      = w_addr;
    o_wr_en_d     = 1'b0;
    o_addr_d      = o_addr;
    o_wdata_d     = o_wdata;
    wd_hit        = (wd_q == WD_W'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_k == 8'd0 || cfg_k > 8'(K_MAX)) begin
            err_cfg_d = 1'b1;
          end else if (cfg_tiles == 8'd0) begin
            irq_done_d = 1'b1;
          end else begin
            k_d           = cfg_k;
            tiles_d       = cfg_tiles;
            w_base_d      = cfg_w_base;
            err_timeout_d = 1'b0;
            busy_d        = 1'b1;
            tile_idx_d    = 8'd0;
            j_d           = 8'd0;
            a_addr_d      = cfg_a_base;
            w_addr_d      = cfg_w_base;
            o_addr_d      = cfg_o_base;
            a_rd_en_d     = 1'b1;
            w_rd_en_d     = 1'b1;
            state_d       = STREAM;
          end
        end
      end

      STREAM: begin
        a_addr_d = a_addr + ADDR_W'(1);
        w_addr_d = w_addr + ADDR_W'(1);
        j_d      = j_q + 8'd1;
        if (j_q == k_q - 8'd1) begin
          state_d = FLUSH;
        end else begin
          a_rd_en_d = 1'b1;
          w_rd_en_d = 1'b1;
        end
      end

      FLUSH: begin
        wd_d    = '0;
        state_d = WAIT;
      end

      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (wd_hit) begin
          err_timeout_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else if (tpu_out_valid) begin
          row_d     = '0;
          o_wr_en_d = 1'b1;
          o_wdata_d = tpu_do;
          state_d   = DRAIN;
        end
      end

      DRAIN: begin
        wd_d = wd_q + WD_W'(1);
        if (wd_hit) begin
          err_timeout_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          o_addr_d = o_addr + ADDR_W'(1);
          row_d    = row_q + ROWS_W'(1);
          if (row_q == ROWS_W'(15)) begin
            state_d = NEXT;
          end else begin
            o_wr_en_d = 1'b1;
            o_wdata_d = tpu_do;
          end
        end
      end

      NEXT: begin
        if (tile_idx == tiles_q - 8'd1) begin
          busy_d     = 1'b0;
          irq_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tile_idx_d = tile_idx + 8'd1;
          j_d        = 8'd0;
          w_addr_d   = w_base_q;
          a_rd_en_d  = 1'b1;
          w_rd_en_d  = 1'b1;
          state_d    = STREAM;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_q          <= '0;
      row_q        <= '0;
      wd_q         <= '0;
      k_q          <= '0;
      tiles_q      <= '0;
      w_base_q     <= '0;
      busy         <= 1'b0;
      irq_done     <= 1'b0;
      err_cfg      <= 1'b0;
      err_timeout  <= 1'b0;
      tile_idx     <= '0;
      a_rd_en      <= 1'b0;
      w_rd_en      <= 1'b0;
      a_addr       <= '0;
      w_addr       <= '0;
      tpu_in_valid <= 1'b0;
      o_wr_en      <= 1'b0;
      o_addr       <= '0;
      o_wdata      <= '0;
    end else begin
      j_q          <= j_d;
      row_q        <= row_d;
      wd_q         <= wd_d;
      k_q          <= k_d;
      tiles_q      <= tiles_d;
      w_base_q     <= w_base_d;
      busy         <= busy_d;
      irq_done     <= irq_done_d;
      err_cfg      <= err_cfg_d;
      err_timeout  <= err_timeout_d;
      tile_idx     <= tile_idx_d;
      a_rd_en      <= a_rd_en_d;
      w_rd_en      <= w_rd_en_d;
      a_addr       <= a_addr_d;
      w_addr       <= w_addr_d;
      tpu_in_valid <= a_rd_en;
      o_wr_en      <= o_wr_en_d;
      o_addr       <= o_addr_d;
      o_wdata      <= o_wdata_d;
    end
  end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Scoreboard bench for tpu_tile_sequencer with SRAM and TPU behavioural models.
module tb_tpu_tile_sequencer;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned K_MAX   = 144;
  localparam int unsigned TIMEOUT = 511;

  localparam int EV_IRQ  = 1;
  localparam int EV_CFG  = 2;
  localparam int EV_TO   = 3;
  localparam int EV_IRQ0 = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        tile;
  } rd_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [127:0]      data;
  } wr_t;

  logic              clk, rst, start;
  logic [7:0]        cfg_k, cfg_tiles;
  logic [ADDR_W-1:0] cfg_a_base, cfg_w_base, cfg_o_base;
  logic              busy, irq_done, err_cfg, err_timeout;
  logic [7:0]        tile_idx;
  logic              a_rd_en, w_rd_en, tpu_in_valid, o_wr_en;
  logic [ADDR_W-1:0] a_addr, w_addr, o_addr;
  logic [127:0]      a_rdata, w_rdata, tpu_mat_di, tpu_wei_di, o_wdata;
  logic              tpu_out_valid, tpu_done;
  logic [127:0]      tpu_do;

  tpu_tile_sequencer #(.ADDR_W(ADDR_W), .K_MAX(K_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
    .cfg_a_base(cfg_a_base), .cfg_w_base(cfg_w_base), .cfg_o_base(cfg_o_base),
    .busy(busy), .irq_done(irq_done), .err_cfg(err_cfg), .err_timeout(err_timeout),
    .tile_idx(tile_idx),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .tpu_in_valid(tpu_in_valid), .tpu_mat_di(tpu_mat_di), .tpu_wei_di(tpu_wei_di),
    .tpu_out_valid(tpu_out_valid), .tpu_do(tpu_do), .tpu_done(tpu_done),
    .o_wr_en(o_wr_en), .o_addr(o_addr), .o_wdata(o_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] a_mem [0:(1<<ADDR_W)-1];
  logic [127:0] w_mem [0:(1<<ADDR_W)-1];

  rd_t               exp_a[$];
  logic [ADDR_W-1:0] exp_w[$];
  logic [255:0]      exp_in[$];
  wr_t               exp_o[$];
  int                exp_ev[$];

  // Shared state between stimulus, TPU model and monitor.
  int          cur_k, tpu_tile, owrites, burst_end_cyc, to_cyc, last_hi;
  bit          tpu_hang;
  logic [31:0] salt;
  logic        prev_busy, prev_to;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got DUT activity expected none (cycle %0d)", name, cyc);
  endtask

  // Result row the TPU model returns for a given tile/row of the current job.
  function automatic logic [127:0] res(input int t, input int r, input logic [31:0] s);
    return {s, 32'(t), 32'(r), s ^ 32'(t * 16 + r)};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAMs with one-cycle read latency; garbage on cycles without a read.
  always @(posedge clk) begin
    a_rdata <= a_rd_en ? a_mem[a_addr] : {$urandom, $urandom, $urandom, $urandom};
    w_rdata <= w_rd_en ? w_mem[w_addr] : {$urandom, $urandom, $urandom, $urandom};
  end

  // TPU model: counts each input burst, then after a random latency emits
  // a valid pulse with row 0 followed by rows 1..15 on consecutive cycles.
  initial begin
    int beats;
    int lat;
    beats = 0;
    last_hi = 0;
    tpu_out_valid = 1'b0;
    tpu_done = 1'b0;
    tpu_do = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        beats = 0;
      end else if (tpu_in_valid) begin
        if (beats == 0 && tpu_tile > 0)
          chk("ivalid_gap>=3", 128'((cyc - last_hi - 1) >= 3), 128'd1);
        beats++;
        last_hi = cyc;
      end else if (beats > 0) begin
        burst_end_cyc = cyc;
        chk("burst_beats", 128'(beats), 128'(cur_k));
        beats = 0;
        if (!tpu_hang) begin
          lat = $urandom_range(0, 12);
          repeat (lat) @(negedge clk);
          for (int r = 0; r < 16; r++) begin
            tpu_out_valid = (r == 0);
            tpu_done = (r == 15);
            tpu_do = res(tpu_tile, r, salt);
            @(negedge clk);
          end
          tpu_out_valid = 1'b0;
          tpu_done = 1'b0;
          tpu_do = {$urandom, $urandom, $urandom, $urandom};
        end
        tpu_tile++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin : monitor
    rd_t          ra;
    wr_t          wo;
    logic [255:0] din;
    int           ev;
    if (rst) begin
      if (a_rd_en) begin
        if (exp_a.size() == 0) flag("a_rd_unexpected");
        else begin
          ra = exp_a.pop_front();
          chk("a_addr", 128'(a_addr), 128'(ra.addr));
          chk("tile_idx", 128'(tile_idx), 128'(ra.tile));
        end
      end
      if (w_rd_en) begin
        if (exp_w.size() == 0) flag("w_rd_unexpected");
        else chk("w_addr", 128'(w_addr), 128'(exp_w.pop_front()));
      end
      if (tpu_in_valid) begin
        if (exp_in.size() == 0) flag("in_valid_unexpected");
        else begin
          din = exp_in.pop_front();
          chk("tpu_mat_di", tpu_mat_di, din[255:128]);
          chk("tpu_wei_di", tpu_wei_di, din[127:0]);
        end
      end else begin
        chk("di_gated", tpu_mat_di | tpu_wei_di, 128'd0);
      end
      if (o_wr_en) begin
        owrites++;
        if (exp_o.size() == 0) flag("o_wr_unexpected");
        else begin
          wo = exp_o.pop_front();
          chk("o_addr", 128'(o_addr), 128'(wo.addr));
          chk("o_wdata", o_wdata, wo.data);
        end
      end
      if (irq_done) begin
        if (exp_ev.size() == 0) flag("irq_unexpected");
        else begin
          ev = exp_ev.pop_front();
          chk("irq_event", 128'(ev == EV_IRQ || ev == EV_IRQ0), 128'd1);
          chk("irq_busy_low", 128'(busy), 128'd0);
          chk("irq_prev_busy", 128'(prev_busy), 128'(ev == EV_IRQ));
        end
      end
      if (err_cfg) begin
        if (exp_ev.size() == 0) flag("err_cfg_unexpected");
        else chk("err_cfg_event", 128'(exp_ev.pop_front()), 128'(EV_CFG));
      end
      if (err_timeout && !prev_to) begin
        to_cyc = cyc;
        if (exp_ev.size() == 0) flag("timeout_unexpected");
        else chk("timeout_event", 128'(exp_ev.pop_front()), 128'(EV_TO));
      end
    end
    prev_busy = busy;
    prev_to = err_timeout;
  end

  // Push the expected response of a job, then pulse start with its config.
  task automatic issue_job(input int k, input int tiles, input int ab, input int wb,
                           input int ob, input bit hang);
    rd_t ra;
    wr_t wo;
    logic [ADDR_W-1:0] aa, wa;
    salt = $urandom;
    tpu_tile = 0;
    tpu_hang = hang;
    cur_k = k;
    owrites = 0;
    if (k == 0 || k > int'(K_MAX)) exp_ev.push_back(EV_CFG);
    else if (tiles == 0) exp_ev.push_back(EV_IRQ0);
    else begin
      for (int t = 0; t < (hang ? 1 : tiles); t++) begin
        for (int j = 0; j < k; j++) begin
          aa = ADDR_W'(ab + t * k + j);
          wa = ADDR_W'(wb + j);
          ra.addr = aa;
          ra.tile = 8'(t);
          exp_a.push_back(ra);
          exp_w.push_back(wa);
          exp_in.push_back({a_mem[aa], w_mem[wa]});
        end
        if (!hang) begin
          for (int r = 0; r < 16; r++) begin
            wo.addr = ADDR_W'(ob + t * 16 + r);
            wo.data = res(t, r, salt);
            exp_o.push_back(wo);
          end
        end
      end
      exp_ev.push_back(hang ? EV_TO : EV_IRQ);
    end
    @(negedge clk);
    start = 1'b1;
    cfg_k = 8'(k);
    cfg_tiles = 8'(tiles);
    cfg_a_base = ADDR_W'(ab);
    cfg_w_base = ADDR_W'(wb);
    cfg_o_base = ADDR_W'(ob);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_a.size() + exp_w.size() + exp_in.size() + exp_o.size() + exp_ev.size() != 0
            || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) flag({name, "_timeout"});
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int bh, k, t, n;
    rst = 1'b0;
    start = 1'b0;
    cfg_k = '0;
    cfg_tiles = '0;
    cfg_a_base = '0;
    cfg_w_base = '0;
    cfg_o_base = '0;
    tpu_hang = 1'b0;
    salt = '0;
    cur_k = 0;
    tpu_tile = 0;
    owrites = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      a_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      w_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 128'({busy, irq_done, err_cfg, err_timeout, tile_idx, a_rd_en, a_addr,
                            w_rd_en, w_addr, tpu_in_valid, o_wr_en, o_addr}), 128'd0);
    chk("reset_data", tpu_mat_di | tpu_wei_di | o_wdata, 128'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic single tile and a full-length three tile job.
    issue_job(4, 1, 'h000, 'h100, 'h200, 1'b0);
    wait_done("job_k4");
    chk("writes_k4", 128'(owrites), 128'd16);
    issue_job(144, 3, 'h000, 'h100, 'h200, 1'b0);
    wait_done("job_k144");
    chk("writes_k144", 128'(owrites), 128'd48);

    // Rejected configurations and empty job.
    foreach (exp_ev[i]) exp_ev.delete(i);
    for (int c = 0; c < 2; c++) begin
      issue_job(c == 0 ? 0 : 145, 2, 0, 0, 0, 1'b0);
      bh = 0;
      repeat (6) begin @(negedge clk); bh |= int'(busy); end
      chk("badk_busy_low", 128'(bh), 128'd0);
      wait_done("badk");
    end
    issue_job(5, 0, 0, 0, 0, 1'b0);
    chk("empty_irq_next_cycle", 128'(irq_done), 128'd1);
    bh = int'(busy);
    repeat (4) begin @(negedge clk); bh |= int'(busy); end
    chk("empty_busy_low", 128'(bh), 128'd0);
    wait_done("empty");

    // Watchdog abort, then recovery on the next accepted start.
    issue_job(8, 2, 'h010, 'h020, 'h300, 1'b1);
    wait_done("hang");
    chk("timeout_delay", 128'(to_cyc - burst_end_cyc), 128'(TIMEOUT));
    chk("timeout_sticky", 128'(err_timeout), 128'd1);
    chk("timeout_no_writes", 128'(owrites), 128'd0);
    issue_job(5, 2, 'h040, 'h050, 'h060, 1'b0);
    chk("timeout_cleared", 128'(err_timeout), 128'd0);
    chk("busy_after_start", 128'(busy), 128'd1);
    wait_done("recover");
    chk("writes_recover", 128'(owrites), 128'd32);

    // Reset during DRAIN of tile 1.
    issue_job(6, 3, 'h100, 'h200, 'h300, 1'b0);
    n = 0;
    while (!(o_wr_en && tile_idx == 8'd1) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) flag("reach_drain_tile1");
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    exp_a.delete(); exp_w.delete(); exp_in.delete(); exp_o.delete(); exp_ev.delete();
    #1;
    chk("midjob_reset_ctrl", 128'({busy, irq_done, err_cfg, err_timeout, tile_idx, a_rd_en,
                                   a_addr, w_rd_en, w_addr, tpu_in_valid, o_wr_en, o_addr}),
        128'd0);
    chk("midjob_reset_data", tpu_mat_di | tpu_wei_di | o_wdata, 128'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);

    // Job with a second start pulse while busy.
    issue_job(7, 2, 'h3F8, 'h3FC, 'h3F0, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1; cfg_k = 8'd3; cfg_tiles = 8'd1; cfg_a_base = '0; cfg_o_base = '0;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    chk("writes_busy_start", 128'(owrites), 128'd32);

    // Randomised jobs with wrapping bases.
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(1, 24);
      t = $urandom_range(1, 4);
      issue_job(k, t, $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), 1'b0);
      wait_done("random");
      chk("writes_random", 128'(owrites), 128'(16 * t));
    end

    chk("queues_drained", 128'(exp_a.size() + exp_w.size() + exp_in.size() + exp_o.size()
                                + exp_ev.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
Controller that runs a sequence of matrix tiles through the 16x16 systolic TPU datapath without CPU intervention. The CPU programs the tile count, reduction length and buffer base addresses, then pulses start. For each tile the block streams K activation/weight vectors from two SRAM buffers into the TPU, waits for results, and writes the 16 result rows to an output buffer. It sits between the host register file, the A/W/O scratchpad SRAMs and the TPU core.

Parameters:
ADDR_W, 10, SRAM word-address width for the A, W and O buffers
K_MAX, 144, maximum reduction length per tile (16 channels x 9 taps)
TIMEOUT, 511, maximum cycles allowed in WAIT+DRAIN per tile before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts a job (ignored while busy)
cfg_k  in  8  vectors per tile, valid range 1..K_MAX
cfg_tiles  in  8  number of tiles, 0..255
cfg_a_base  in  ADDR_W  activation buffer base
cfg_w_base  in  ADDR_W  weight buffer base (weights shared by all tiles)
cfg_o_base  in  ADDR_W  output buffer base
busy  out  1  high from accepted start until job end
irq_done  out  1  one-cycle pulse on successful job completion
err_cfg  out  1  one-cycle pulse when start is rejected for bad cfg_k
err_timeout  out  1  sticky abort flag, cleared by the next accepted start
tile_idx  out  8  index of the tile currently in progress
a_rd_en  out  1  A buffer read enable, read latency 1 cycle
a_addr  out  ADDR_W  A buffer read address
a_rdata  in  128  A buffer read data
w_rd_en  out  1  W buffer read enable, read latency 1 cycle
w_addr  out  ADDR_W  W buffer read address
w_rdata  in  128  W buffer read data
tpu_in_valid  out  1  TPU input-vector valid
tpu_mat_di  out  128  activation vector to TPU (16 x 8-bit)
tpu_wei_di  out  128  weight vector to TPU (16 x 8-bit)
tpu_out_valid  in  1  TPU result-ready pulse
tpu_do  in  128  TPU result row
tpu_done  in  1  TPU last-row indicator
o_wr_en  out  1  output buffer write enable
o_addr  out  ADDR_W  output buffer write address
o_wdata  out  128  output buffer write data

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- States: IDLE, STREAM, FLUSH, WAIT, DRAIN, NEXT.
- IDLE: on start, if cfg_k is 0 or greater than K_MAX, pulse err_cfg and stay in IDLE. If cfg_tiles is 0, pulse irq_done the next cycle with busy held low. Otherwise latch all cfg_* values, clear err_timeout, set busy, set tile_idx and j to 0, and go to STREAM.
- STREAM: each cycle assert a_rd_en and w_rd_en with a_addr = a_base + tile_idx*k + j and w_addr = w_base + j, then increment j. After the read with j = k-1, go to FLUSH. Address arithmetic wraps modulo 2^ADDR_W.
- tpu_in_valid is a_rd_en delayed by one register stage. tpu_mat_di and tpu_wei_di are a_rdata and w_rdata passed straight through, and are 0 whenever tpu_in_valid is low. The result is exactly k consecutive in_valid cycles, with no gaps.
- FLUSH: one cycle that retires the last read. Go to WAIT. tpu_in_valid is guaranteed low from WAIT onward.
- WAIT: the watchdog counter runs. On sampling tpu_out_valid high, set row to 0 and go to DRAIN.
- DRAIN: each cycle assert o_wr_en with o_addr = o_base + tile_idx*16 + row and o_wdata = tpu_do, then increment row. After the write with row = 15, go to NEXT. tpu_done is ignored for sequencing.
- NEXT: if tile_idx = tiles-1, deassert busy, pulse irq_done and go to IDLE. Otherwise increment tile_idx, clear j and go to STREAM. This guarantees at least 3 cycles with in_valid low between tiles.
- Watchdog: cleared on entry to WAIT and counts every WAIT/DRAIN cycle. Reaching TIMEOUT sets err_timeout, drops busy, suppresses irq_done, stops any further writes and returns to IDLE.
- start while busy is ignored, with no error.
- Asynchronous reset mid-job returns to IDLE at once. No partial completion is reported.
- Per-tile latency from the first a_rd_en to the first o_wr_en is k + 2 + (TPU result latency) cycles.

Test Plan:
- k=4, tiles=1, a_base=0x000, w_base=0x100, o_base=0x200, TPU model returns rows 0..15 -> a_addr 0..3 and w_addr 0x100..0x103; tpu_in_valid high for exactly 4 cycles; 16 writes to o_addr 0x200..0x20F with matching data; busy falls in the same cycle irq_done pulses once.
- k=144, tiles=3 -> A reads span 0..431 and W reads repeat 0x100..0x18F three times; outputs land at 0x200..0x22F; tile_idx steps 0, 1, 2; in_valid is low for at least 3 cycles between bursts.
- start with cfg_k=0, and separately with cfg_k=145 -> err_cfg pulses once, busy stays 0, no SRAM or TPU activity.
- cfg_tiles=0 -> irq_done pulses one cycle after start, busy never rises.
- TPU model never asserts out_valid, TIMEOUT=511 -> err_timeout set 511 cycles after entering WAIT, busy drops, no irq_done; the next valid start clears err_timeout and the job completes normally.
- Reset asserted during DRAIN of tile 1, then released -> all outputs 0, no further o_wr_en; a second start with a second start pulse sent while busy is ignored and the job finishes with exactly 16*tiles writes.
